// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: checks SYNC/PID, sorts packets by type and sends DATA payload to the RX FIFO.
// A 2-byte holdoff keeps the CRC16 trailer out of the FIFO.
module usb_rx_pkt_ctrl #(
  parameter int unsigned MAX_DATA = 64,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       byte_complete,
  input  logic [7:0] rx_byte,
  input  logic       eop,
  input  logic       stuff_err,
  input  logic       crc5_ok,
  input  logic       crc16_ok,
  input  logic       fifo_full,
  output logic       enable_timer,
  output logic [2:0] rx_packet,
  output logic [7:0] rx_packet_data,
  output logic       store_rx_packet_data,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = $clog2(MAX_DATA + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_HS, S_DATA, S_ERR, S_DONE
  } state_t;

  state_t         state, state_next;
  logic [2:0]     result, result_next;
  logic           err_eop, err_eop_next;
  logic [7:0]     h0, h1;
  logic [1:0]     fill, tok_cnt;
  logic [CW-1:0]  stored;
  logic [TW-1:0]  timer;
  logic           store_req, shift, tok_inc, timed_out;
  logic [2:0]     code;

  function automatic logic [2:0] pid_code(input logic [7:0] b);
    if (b[7:4] != ~b[3:0]) return 3'd7;
    case (b)
      8'hE1:   return 3'd1;
      8'h69:   return 3'd2;
      8'hC3:   return 3'd3;
      8'h4B:   return 3'd4;
      8'hD2:   return 3'd5;
      8'h5A:   return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  assign timed_out    = (timer == TW'(TIMEOUT));
  assign busy         = (state != S_IDLE);
  assign enable_timer = (state != S_IDLE) && (state != S_DONE);
  assign code         = pid_code(rx_byte);

  always_comb begin
    state_next   = state;
    result_next  = result;
    err_eop_next = err_eop;
    store_req    = 1'b0;
    shift        = 1'b0;
    tok_inc      = 1'b0;
    case (state)
      S_IDLE: if (d_edge) state_next = S_SYNC;
      S_DONE: state_next = S_IDLE;
      S_ERR:  if (err_eop || eop || timed_out) state_next = S_DONE;
      default: begin
        if (timed_out) begin
          state_next  = S_DONE;
          result_next = 3'd7;
        end else if (stuff_err) begin
          state_next   = S_ERR;
          err_eop_next = eop;
        end else begin
          // eop takes priority over a byte_complete in the same cycle
          case (state)
            S_SYNC: begin
              if (eop) begin
                state_next   = S_ERR;
                err_eop_next = 1'b1;
              end else if (byte_complete) begin
                state_next = (rx_byte == 8'h80) ? S_PID : S_ERR;
              end
            end
            S_PID: begin
              if (eop) begin
                state_next   = S_ERR;
                err_eop_next = 1'b1;
              end else if (byte_complete) begin
                result_next = code;
                case (code)
                  3'd1, 3'd2: state_next = S_TOKEN;
                  3'd3, 3'd4: state_next = S_DATA;
                  3'd5, 3'd6: state_next = S_HS;
                  default:    state_next = S_ERR;
                endcase
              end
            end
            S_TOKEN: begin
              if (eop) begin
                if (tok_cnt == 2'd2 && crc5_ok) state_next = S_DONE;
                else begin
                  state_next   = S_ERR;
                  err_eop_next = 1'b1;
                end
              end else if (byte_complete) begin
                if (tok_cnt == 2'd2) state_next = S_ERR;
                else tok_inc = 1'b1;
              end
            end
            S_HS: begin
              if (eop) state_next = S_DONE;
              else if (byte_complete) state_next = S_ERR;
            end
            S_DATA: begin
              if (eop) begin
                if (fill == 2'd2 && crc16_ok) state_next = S_DONE;
                else begin
                  state_next   = S_ERR;
                  err_eop_next = 1'b1;
                end
              end else if (byte_complete) begin
                if (fill != 2'd2) shift = 1'b1;
                else if (fifo_full || stored == CW'(MAX_DATA)) state_next = S_ERR;
                else begin
                  shift     = 1'b1;
                  store_req = 1'b1;
                end
              end
            end
            default: state_next = S_ERR;
          endcase
        end
        if (state_next == S_ERR) result_next = 3'd7;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      result               <= '0;
      err_eop              <= 1'b0;
      rx_packet            <= '0;
      rx_packet_data       <= '0;
      store_rx_packet_data <= 1'b0;
      h0                   <= '0;
      h1                   <= '0;
      fill                 <= '0;
      tok_cnt              <= '0;
      stored               <= '0;
      timer                <= '0;
    end else begin
      state                <= state_next;
      result               <= result_next;
      err_eop              <= err_eop_next;
      store_rx_packet_data <= store_req;
      if (store_req) begin
        rx_packet_data <= h1;
        stored         <= stored + 1'b1;
      end
      if (shift) begin
        h1 <= h0;
        h0 <= rx_byte;
        if (fill != 2'd2) fill <= fill + 1'b1;
      end
      if (tok_inc) tok_cnt <= tok_cnt + 1'b1;
      if (state == S_IDLE || state != state_next || byte_complete || eop)
        timer <= '0;
      else
        timer <= timer + 1'b1;
      if (state == S_DONE) rx_packet <= result;
      if (state == S_IDLE) begin
        fill    <= '0;
        tok_cnt <= '0;
        stored  <= '0;
        err_eop <= 1'b0;
        if (d_edge) rx_packet <= '0;
      end
    end
  end

endmodule
